// File: rtl/icache_types.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } icache_state_t;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WORD_IDX_W = S_OFFSET - 2;

  localparam logic [WORD_W-1:0] NOP = 32'h0000_0013;

  // Tag width left over from a 32-bit address after index and offset
  function automatic int unsigned tag_width(input int unsigned s_index);
    return 32 - s_index - S_OFFSET;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage for the instruction cache: data, tag and valid per line.
// Synchronous write, asynchronous read, single-cycle clear of all valid bits.
module icache_array
  import icache_types::*;
#(
  parameter int unsigned S_INDEX = 3,
  parameter int unsigned TAG_W   = tag_width(3)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_we,
  input  logic [S_INDEX-1:0] i_windex,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [LINE_W-1:0]  i_wdata,
  input  logic [S_INDEX-1:0] i_rindex,
  output logic [LINE_W-1:0]  o_rdata,
  output logic [TAG_W-1:0]   o_rtag,
  output logic               o_rvalid
);

  localparam int unsigned LINES = 32'(1) << S_INDEX;

  logic [LINE_W-1:0] r_data [LINES];
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINES-1:0]  r_valid;

  // Valid bits: cleared by reset or flush, set when a line is filled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_clear) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_windex] <= 1'b1;
    end
  end

  // Line data and tag capture on fill
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[i_windex] <= i_wdata;
      r_tag[i_windex]  <= i_wtag;
    end
  end

  assign o_rdata  = r_data[i_rindex];
  assign o_rtag   = r_tag[i_rindex];
  assign o_rvalid = r_valid[i_rindex];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering IF-stage fetches.
// Misses fill a whole 256-bit line over the pmem read handshake.
// Optional feature: define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache_responder
  import icache_types::*;
#(
  parameter int unsigned S_INDEX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_in,
  input  logic              read_req,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              iresp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned TAG_W = tag_width(S_INDEX);

  icache_state_t r_state, w_state_d;
  logic                  r_iresp, w_iresp_d;
  logic [31:0]           r_inst, w_inst_d;
  logic                  r_pmem_read, w_pmem_read_d;
  logic [31:0]           r_pmem_address, w_pmem_address_d;
  logic [WORD_IDX_W-1:0] r_word, w_word_d;
  logic                  r_flush_pend, w_flush_pend_d;

  logic [TAG_W-1:0]      w_tag;
  logic [S_INDEX-1:0]    w_index;
  logic [WORD_IDX_W-1:0] w_word;
  logic [LINE_W-1:0]     w_rline;
  logic [TAG_W-1:0]      w_rtag;
  logic                  w_rvalid;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_we;
  logic                  w_clear;
  logic                  w_unused;

  assign w_tag    = pc_in[31 -: TAG_W];
  assign w_index  = pc_in[S_OFFSET +: S_INDEX];
  assign w_word   = pc_in[S_OFFSET-1:2];
  assign w_unused = ^pc_in[1:0];

  // A flush in the same cycle wipes the array, so the request cannot hit
  assign w_hit = w_rvalid && (w_rtag == w_tag) && !flush;
  // While iresp is high the held request is the one just answered
  assign w_accept = (r_state == IDLE) && read_req && !r_iresp;

  icache_array #(
    .S_INDEX (S_INDEX),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_we     (w_we && rst_n),
    .i_windex (r_pmem_address[S_OFFSET +: S_INDEX]),
    .i_wtag   (r_pmem_address[31 -: TAG_W]),
    .i_wdata  (pmem_rdata),
    .i_rindex (w_index),
    .o_rdata  (w_rline),
    .o_rtag   (w_rtag),
    .o_rvalid (w_rvalid)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_iresp        <= 1'b0;
      r_inst         <= NOP;
      r_pmem_read    <= 1'b0;
      r_pmem_address <= '0;
      r_word         <= '0;
      r_flush_pend   <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_iresp        <= w_iresp_d;
      r_inst         <= w_inst_d;
      r_pmem_read    <= w_pmem_read_d;
      r_pmem_address <= w_pmem_address_d;
      r_word         <= w_word_d;
      r_flush_pend   <= w_flush_pend_d;
    end
  end

  // Next-state, fill control and next output values
  always_comb begin
    w_state_d        = r_state;
    w_iresp_d        = 1'b0;
    w_inst_d         = r_inst;
    w_pmem_read_d    = r_pmem_read;
    w_pmem_address_d = r_pmem_address;
    w_word_d         = r_word;
    w_flush_pend_d   = r_flush_pend;
    w_we             = 1'b0;
    w_clear          = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_clear        = flush;
        w_flush_pend_d = 1'b0;
        if (w_accept) begin
          if (w_hit) begin
            w_iresp_d = 1'b1;
            w_inst_d  = w_rline[{w_word, 5'd0} +: WORD_W];
          end else begin
            w_state_d        = FILL;
            w_pmem_read_d    = 1'b1;
            w_pmem_address_d = {pc_in[31:S_OFFSET], S_OFFSET'(0)};
            w_word_d         = w_word;
          end
        end
      end
      FILL: begin
        if (flush) begin
          w_flush_pend_d = 1'b1;
        end
        if (pmem_resp) begin
          w_we          = 1'b1;
          w_pmem_read_d = 1'b0;
          w_iresp_d     = 1'b1;
          w_inst_d      = pmem_rdata[{r_word, 5'd0} +: WORD_W];
          w_state_d     = RESP;
        end
      end
      RESP: begin
        // Deferred flush lands after the response, including one arriving now
        w_clear        = r_flush_pend || flush;
        w_flush_pend_d = 1'b0;
        w_state_d      = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  assign inst         = r_inst;
  assign iresp        = r_iresp;
  assign pmem_read    = r_pmem_read;
  assign pmem_address = r_pmem_address;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Saturating hit/miss counters, bumped at the IDLE decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
      end else begin
        if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  // The requester must hold its fetch steady while the line is being filled
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == FILL) |-> (read_req && (pc_in[31:2] == {r_pmem_address[31:S_OFFSET], r_word})));

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder; expected words queued at request time.
// Build with ICACHE_PERF_EN defined to also cover the hit/miss counters.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  pc_in;
  logic         read_req;
  logic         flush;
  logic [31:0]  inst;
  logic         iresp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_inst;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .read_req     (read_req),
    .flush        (flush),
    .inst         (inst),
    .iresp        (iresp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backing-memory model: one fixed word, everything else address-derived
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa == 32'h0000_0048) return 32'hDEAD_BEEF;
    return wa ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = word_of({base[31:5], 3'(i), 2'b00});
    return l;
  endfunction

  // One fetch; fl_mode 1 = flush with the request, 2 = flush during the fill
  task automatic fetch(input string nm, input logic [31:0] pc, input bit exp_miss, input int fl_mode);
    logic [31:0] e;
    pc_in    = pc;
    read_req = 1'b1;
    flush    = (fl_mode == 1);
    exp_q.push_back(word_of(pc));
    tick();
    flush = 1'b0;
    if (exp_miss) begin
      total++;
      if (pmem_read !== 1'b1 || iresp !== 1'b0) begin
        bad++;
        $display("FAIL %s miss_start: pmem_read=%b iresp=%b, required 1/0", nm, pmem_read, iresp);
      end
      total++;
      if (pmem_address !== {pc[31:5], 5'b0}) begin
        bad++;
        $display("FAIL %s fill_addr: got %h, required %h", nm, pmem_address, {pc[31:5], 5'b0});
      end
      for (int i = 0; i < 3; i++) begin
        if (fl_mode == 2 && i == 1) flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (pmem_read !== 1'b1 || iresp !== 1'b0 || pmem_address !== {pc[31:5], 5'b0}) begin
          bad++;
          $display("FAIL %s fill_hold: pmem_read=%b iresp=%b addr=%h, required 1/0/%h",
                   nm, pmem_read, iresp, pmem_address, {pc[31:5], 5'b0});
        end
      end
      pmem_rdata = line_of({pc[31:5], 5'b0});
      pmem_resp  = 1'b1;
      tick();
      pmem_resp  = 1'b0;
      pmem_rdata = {8{32'($urandom)}};
      total++;
      if (pmem_read !== 1'b0) begin
        bad++;
        $display("FAIL %s fill_drop: pmem_read=%b, required 0", nm, pmem_read);
      end
    end else begin
      total++;
      if (pmem_read !== 1'b0) begin
        bad++;
        $display("FAIL %s hit_nofill: pmem_read=%b, required 0", nm, pmem_read);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (iresp !== 1'b1 || inst !== e) begin
      bad++;
      $display("FAIL %s resp: iresp=%b inst=%h, required 1/%h", nm, iresp, inst, e);
    end
    last_inst = e;
    // Request still held during the iresp cycle: must not be answered twice
    tick();
    total++;
    if (iresp !== 1'b0) begin
      bad++;
      $display("FAIL %s single_pulse: iresp=%b, required 0", nm, iresp);
    end
    read_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    read_req   = 1'b0;
    flush      = 1'b0;
    pmem_resp  = 1'b0;
    pc_in      = '0;
    pmem_rdata = '0;
    tick();
    tick();
    total++;
    if (iresp !== 1'b0 || pmem_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: iresp=%b pmem_read=%b, required 0/0", iresp, pmem_read);
    end
    total++;
    if (inst !== 32'h0000_0013) begin
      bad++;
      $display("FAIL reset_inst: got %h, required 00000013", inst);
    end
    total++;
    if (pmem_address !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr: got %h, required 00000000", pmem_address);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_miss_fill();
    fetch("miss_0x48", 32'h0000_0048, 1'b1, 0);
  endtask

  task automatic test_hit();
    fetch("hit_0x4c", 32'h0000_004C, 1'b0, 0);
    fetch("hit_0x40", 32'h0000_0040, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (iresp !== 1'b0 || inst !== last_inst) begin
        bad++;
        $display("FAIL idle_hold: iresp=%b inst=%h, required 0/%h", iresp, inst, last_inst);
      end
    end
  endtask

  task automatic test_back_to_back();
    fetch("b2b_0x44", 32'h0000_0044, 1'b0, 0);
    fetch("b2b_0x50", 32'h0000_0050, 1'b0, 0);
    fetch("b2b_0x5c", 32'h0000_005C, 1'b0, 0);
  endtask

  task automatic test_conflict();
    fetch("conf_0x140", 32'h0000_0140, 1'b1, 0);
    fetch("conf_0x40",  32'h0000_0040, 1'b1, 0);
    fetch("conf_0x144", 32'h0000_0144, 1'b1, 0);
  endtask

  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch("fl_idle_miss",  32'h0000_0148, 1'b1, 0);
    fetch("fl_idle_hit",   32'h0000_014C, 1'b0, 0);
    fetch("fl_in_fill",    32'h0000_0064, 1'b1, 2);
    fetch("fl_after_0x60", 32'h0000_0060, 1'b1, 0);
    fetch("fl_after_0x140", 32'h0000_0140, 1'b1, 0);
    fetch("fl_hit_again",  32'h0000_0140, 1'b0, 0);
    fetch("fl_same_cycle", 32'h0000_0140, 1'b1, 1);
  endtask

  task automatic test_reset_mid_fill();
    pc_in    = 32'h0000_0080;
    read_req = 1'b1;
    tick();
    total++;
    if (pmem_read !== 1'b1) begin
      bad++;
      $display("FAIL rmf_start: pmem_read=%b, required 1", pmem_read);
    end
    tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (pmem_read !== 1'b0 || iresp !== 1'b0) begin
      bad++;
      $display("FAIL rmf_drop: pmem_read=%b iresp=%b, required 0/0", pmem_read, iresp);
    end
    rst_n      = 1'b1;
    read_req   = 1'b0;
    pmem_rdata = line_of(32'h0000_0080);
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (iresp !== 1'b0 || pmem_read !== 1'b0 || inst !== 32'h0000_0013) begin
        bad++;
        $display("FAIL rmf_late_resp: iresp=%b pmem_read=%b inst=%h, required 0/0/00000013",
                 iresp, pmem_read, inst);
      end
      tick();
    end
    fetch("rmf_refetch", 32'h0000_0080, 1'b1, 0);
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    test_reset();
    fetch("perf_miss1", 32'h0000_0100, 1'b1, 0);
    fetch("perf_hit1",  32'h0000_0104, 1'b0, 0);
    fetch("perf_hit2",  32'h0000_0108, 1'b0, 0);
    fetch("perf_miss2", 32'h0000_0200, 1'b1, 0);
    total++;
    if (hit_count !== 32'd2 || miss_count !== 32'd2) begin
      bad++;
      $display("FAIL perf_counts: hit=%0d miss=%0d, required 2/2", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
